// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue.
//   IFQ_DEPTH_DEFAULT : default number of queue entries
//   ifq_ptr_w()       : pointer width for a given depth
//   ifq_entry_t       : {pc, instr, adel} record at the default pipeline widths
package ifq_pkg;

  localparam int IFQ_DEPTH_DEFAULT = 4;
  localparam int IFQ_ADDR_W        = 32;
  localparam int IFQ_DATA_W        = 32;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] instr;
    logic                  adel;
  } ifq_entry_t;

  // Width of a pointer that indexes 'depth' entries (at least 1 bit).
  function automatic int ifq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifq_ram.sv
// Entry storage for the instruction fetch queue.
// DEPTH x W register array, one synchronous write port, asynchronous read.
// Storage is deliberately not reset; validity is tracked by the pointer logic.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write entry
//   i_raddr : read index
//   o_rdata : entry at i_raddr (combinational)
module ifq_ram
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEFAULT,
  parameter int W     = 65
) (
  input  logic                        i_clk,
  input  logic                        i_we,
  input  logic [ifq_ptr_w(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]                i_wdata,
  input  logic [ifq_ptr_w(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]                o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between fetch (pc / instruction SRAM response) and
// the decode pipeline register. Absorbs decode stalls up to DEPTH entries,
// discards everything on a redirect (flush) and tags each entry with a
// fetch address-error flag (pc[1:0] != 0).
// Optional feature macro: IFQ_BYPASS_EN -- when the queue is empty a pushed
// entry is presented at the head in the same cycle (zero-cycle latency).
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : redirect, discards all entries
//   push_valid/push_ready : fetch-side handshake (push_ready = !full && !flush)
//   push_pc, push_instr   : fetched entry
//   pop_valid/pop_ready   : decode-side handshake
//   pop_pc, pop_instr     : head entry, zero when pop_valid=0
//   pop_adel              : head pc misaligned, zero when pop_valid=0
//   count                 : current occupancy
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = IFQ_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [ADDR_W-1:0]         push_pc,
  input  logic [DATA_W-1:0]         push_instr,
  output logic                      pop_valid,
  input  logic                      pop_ready,
  output logic [ADDR_W-1:0]         pop_pc,
  output logic [DATA_W-1:0]         pop_instr,
  output logic                      pop_adel,
  output logic [ifq_ptr_w(DEPTH):0] count
);

  localparam int PTR_W = ifq_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic             w_wr;
  logic             w_rd;
  logic             w_push_adel;
  logic [ENT_W-1:0] w_wdata;
  logic [ENT_W-1:0] w_rdata;
  logic [ADDR_W-1:0] w_head_pc;
  logic [DATA_W-1:0] w_head_instr;
  logic              w_head_adel;

  assign w_full      = (r_cnt == CNT_W'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_push_adel = |push_pc[1:0];

`ifdef IFQ_BYPASS_EN
  // Empty queue: the incoming entry is forwarded straight to the head.
  assign w_byp = w_empty && push_valid && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // Flush blocks both handshakes; push_ready never looks at pop_ready.
  assign push_ready = !w_full && !flush;
  assign pop_valid  = (!w_empty || w_byp) && !flush;

  assign w_push = push_valid && push_ready;
  assign w_pop  = pop_valid && pop_ready;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign w_wr   = w_push && !(w_byp && pop_ready);
  assign w_rd   = w_pop && !w_byp;

  assign w_wdata = {push_pc, push_instr, w_push_adel};

  ifq_ram #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr && !rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_head_pc    = w_rdata[ENT_W-1 -: ADDR_W];
    w_head_instr = w_rdata[DATA_W:1];
    w_head_adel  = w_rdata[0];
    if (w_byp) begin
      w_head_pc    = push_pc;
      w_head_instr = push_instr;
      w_head_adel  = w_push_adel;
    end
  end

  assign pop_pc    = pop_valid ? w_head_pc    : '0;
  assign pop_instr = pop_valid ? w_head_instr : '0;
  assign pop_adel  = pop_valid && w_head_adel;
  assign count     = r_cnt;

  // Pointer / occupancy state
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
